// File: rtl/fetch_if.sv
// fetch_if: fetch unit bundle of memory, decode and redirect signals; misaligned exists with FETCH_MISALIGN_TRAP_EN.
interface fetch_if #(parameter int WIDTH = 32);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic [31:0]      instruction;
  logic [WIDTH-1:0] pc;
  logic             valid;
  logic             ready;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic             misaligned;
  modport master(output imem_req, imem_addr, instruction, pc, valid, misaligned,
                 input imem_rvalid, imem_rdata, ready, redirect, redirect_pc);
  modport slave(input imem_req, imem_addr, instruction, pc, valid, misaligned,
                output imem_rvalid, imem_rdata, ready, redirect, redirect_pc);
`else
  modport master(output imem_req, imem_addr, instruction, pc, valid,
                 input imem_rvalid, imem_rdata, ready, redirect, redirect_pc);
  modport slave(input imem_req, imem_addr, instruction, pc, valid,
                output imem_rvalid, imem_rdata, ready, redirect, redirect_pc);
`endif
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with in-order response buffer and redirect squash; FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_oq [DEPTH];
  logic [AW-1:0]    r_oq_wr, r_oq_rd;
  logic [CW-1:0]    r_outst, r_drop, r_cnt;
  logic [WIDTH-1:0] r_buf_pc [DEPTH];
  logic [31:0]      r_buf_ins [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic             w_req, w_push, w_pop, w_mis, w_valid;
  logic [WIDTH-1:0] w_rpc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis          = r_mis;
  assign w_rpc          = bus.redirect_pc;
  assign bus.misaligned = r_mis;
  // each redirect re-evaluates alignment; a misaligned target parks fetch
  always_ff @(posedge clk or posedge rst)
    if (rst) r_mis <= 1'b0;
    else if (bus.redirect) r_mis <= |bus.redirect_pc[1:0];
`else
  assign w_mis = 1'b0;
  assign w_rpc = bus.redirect_pc & ~WIDTH'(3);
`endif
  // requests in flight are counted whether or not they will be dropped
  assign w_req   = !rst && !bus.redirect && !w_mis && ({1'b0, r_cnt} + {1'b0, r_outst} < LIM);
  assign w_push  = bus.imem_rvalid && !bus.redirect && r_drop == '0;
  assign w_valid = r_cnt != '0;
  assign w_pop   = w_valid && bus.ready;
  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.valid       = w_valid;
  assign bus.instruction = w_valid ? r_buf_ins[r_rd] : NOP;
  assign bus.pc          = w_valid ? r_buf_pc[r_rd] : RESET_PC;
  // fetch pc, outstanding/drop counters and buffer pointers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
      r_cnt      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_oq_wr    <= '0;
      r_oq_rd    <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_req) - CW'(bus.imem_rvalid);
      r_oq_wr <= r_oq_wr + AW'(w_req);
      r_oq_rd <= r_oq_rd + AW'(bus.imem_rvalid);
      if (bus.redirect) begin
        r_fetch_pc <= w_rpc;
        r_drop     <= r_outst - CW'(bus.imem_rvalid);
        r_cnt      <= '0;
        r_wr       <= '0;
        r_rd       <= '0;
      end else begin
        if (w_req) r_fetch_pc <= r_fetch_pc + WIDTH'(4);
        if (bus.imem_rvalid && r_drop != '0) r_drop <= r_drop - CW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        r_wr  <= r_wr + AW'(w_push);
        r_rd  <= r_rd + AW'(w_pop);
      end
    end
  // request pc queue feeds the pc of each returning word into the buffer
  always_ff @(posedge clk) begin
    if (w_req) r_oq[r_oq_wr] <= r_fetch_pc;
    if (w_push) begin
      r_buf_pc[r_wr]  <= r_oq[r_oq_rd];
      r_buf_ins[r_wr] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-programmable memory model.
module tb_fetch_unit;
  localparam int          WIDTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_if #(.WIDTH(WIDTH)) bus ();
  fetch_unit #(.WIDTH(WIDTH), .RESET_PC('0), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int          n_vec = 0, n_err = 0, cyc = 0, lat = 1, nreq = 0, o_cyc = 0, fc = 0;
  logic        o_req, o_valid, o_rdy, o_rv;
  logic [31:0] o_addr, o_pc, o_ins, exp_pc, exp_addr, dq_a;
  int          dq_d;
  logic [31:0] pq_addr [$];
  int          pq_due [$];
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    o_cyc   = cyc;
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    o_valid = bus.valid;
    o_pc    = bus.pc;
    o_ins   = bus.instruction;
    o_rdy   = bus.ready;
    o_rv    = bus.imem_rvalid;
    if (o_req) begin
      pq_addr.push_back(o_addr);
      pq_due.push_back(cyc + lat);
      nreq++;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rvalid = 1'b0;
    if (pq_due.size() > 0 && pq_due[0] == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word(pq_addr[0]);
      dq_a = pq_addr.pop_front();
      dq_d = pq_due.pop_front();
    end
  endtask
  task automatic hold_rst();
    rst = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.redirect    = 1'b0;
    pq_addr.delete();
    pq_due.delete();
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    cyc  = 0;
    nreq = 0;
  endtask
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (o_valid && o_rdy) begin
        chk("s_pc", o_pc, exp_pc);
        chk("s_ins", o_ins, word(exp_pc));
        exp_pc += 4;
      end
      if (o_req) begin
        chk("s_addr", o_addr, exp_addr);
        exp_addr += 4;
      end
    end
  endtask
  task automatic wait_valid(input int n, output int c);
    c = -1;
    for (int i = 0; i < n && c < 0; i++) begin
      step();
      if (o_valid) c = o_cyc;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.ready       = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    hold_rst();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_ins", bus.instruction, NOP);
    chk("rst_pc", bus.pc, 32'h0);
    release_rst();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t1_req", 32'(o_req), 32'd1);
      chk("t1_addr", o_addr, 32'(4 * c));
      if (c < 2) chk("t1_nvalid", 32'(o_valid), 32'd0);
      else begin
        chk("t1_valid", 32'(o_valid), 32'd1);
        chk("t1_pc", o_pc, 32'(4 * (c - 2)));
        chk("t1_ins", o_ins, word(32'(4 * (c - 2))));
      end
    end
    hold_rst();
    bus.ready = 1'b0;
    lat = 1;
    release_rst();
    repeat (10) step();
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk("t2_req_low", 32'(o_req), 32'd0);
    chk("t2_valid", 32'(o_valid), 32'd1);
    chk("t2_head", o_pc, 32'h0);
    bus.ready = 1'b1;
    exp_pc    = 32'h0;
    exp_addr  = 32'h10;
    stream(8);
    chk("t2_drained", exp_pc, 32'h20);
    hold_rst();
    lat = 3;
    release_rst();
    repeat (3) step();
    chk("t3_nvalid", 32'(o_valid), 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    chk("t3_noreq", 32'(o_req), 32'd0);
    step();
    chk("t3_req", 32'(o_req), 32'd1);
    chk("t3_addr", o_addr, 32'h100);
    wait_valid(20, fc);
    chk("t3_vcyc", 32'(fc), 32'd8);
    chk("t3_pc", o_pc, 32'h100);
    chk("t3_ins", o_ins, word(32'h100));
    hold_rst();
    lat = 1;
    release_rst();
    repeat (5) step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    step();
    bus.redirect = 1'b0;
    chk("t4_rv", 32'(o_rv), 32'd1);
    chk("t4_xfer", 32'(o_valid), 32'd1);
    chk("t4_xpc", o_pc, 32'hC);
    chk("t4_noreq", 32'(o_req), 32'd0);
    step();
    chk("t4_empty", 32'(o_valid), 32'd0);
    chk("t4_addr", o_addr, 32'h300);
    wait_valid(10, fc);
    chk("t4_vcyc", 32'(fc), 32'd8);
    chk("t4_pc", o_pc, 32'h300);
    hold_rst();
    bus.ready = 1'b0;
    release_rst();
    repeat (4) step();
    chk("t5_pre_valid", 32'(bus.valid), 32'd1);
    chk("t5_pre_ins", bus.instruction, word(32'h0));
    #2;
    hold_rst();
    #1;
    chk("t5_valid", 32'(bus.valid), 32'd0);
    chk("t5_req", 32'(bus.imem_req), 32'd0);
    chk("t5_ins", bus.instruction, NOP);
    chk("t5_pc", bus.pc, 32'h0);
    bus.ready = 1'b1;
    release_rst();
    step();
    chk("t5_req1", 32'(o_req), 32'd1);
    chk("t5_addr1", o_addr, 32'h0);
    hold_rst();
    release_rst();
    repeat (2) step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    bus.redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_mis_set", 32'(bus.misaligned), 32'd1);
    nreq = 0;
    repeat (5) step();
    chk("t6_noreq", 32'(nreq), 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect = 1'b0;
    chk("t6_mis_clr", 32'(bus.misaligned), 32'd0);
    step();
    chk("t6_req", 32'(o_req), 32'd1);
    chk("t6_addr", o_addr, 32'h200);
`else
    step();
    chk("t6_req", 32'(o_req), 32'd1);
    chk("t6_addr", o_addr, 32'h100);
    wait_valid(10, fc);
    chk("t6_pc", o_pc, 32'h100);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
